// File: rtl/pio_input_debounced.sv
// Avalon-MM input PIO: two-flop synchronizer, per-bit debounce filter, edge capture
// with write-1-to-clear, and a maskable level interrupt.
module pio_input_debounced #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_MODE       = 2,
    parameter bit          INIT_LEVEL      = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT_LEVEL}};

    logic [WIDTH-1:0] sync1, sync2, stable, stable_d;
    logic [WIDTH-1:0] irqmask, edgecapture;
    logic [WIDTH-1:0] expire, rise, fall, edge_event, clr;
    logic             wr_en, wr_mask, wr_ec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= INIT_VEC;
            sync2    <= INIT_VEC;
            stable   <= INIT_VEC;
            stable_d <= INIT_VEC;
        end else begin
            sync1    <= in_port;
            sync2    <= sync1;
            // expire is only set on a mismatch, so flipping the bit adopts sync2
            stable   <= stable ^ expire;
            stable_d <= stable;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [CW-1:0] cnt;

        assign expire[i] = (sync2[i] != stable[i]) && (cnt == CNT_MAX);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
            end else if ((sync2[i] == stable[i]) || expire[i]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

    always_comb begin
        edge_event = rise | fall;
        case (EDGE_MODE)
            0:       edge_event = rise;
            1:       edge_event = fall;
            default: edge_event = rise | fall;
        endcase
    end

    assign wr_en   = chipselect && !write_n;
    assign wr_mask = wr_en && (address == 2'd2);
    assign wr_ec   = wr_en && (address == 2'd3);
    assign clr     = wr_ec ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_mask) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // a new edge wins over a same-cycle clear
            edgecapture <= (edgecapture & ~clr) | edge_event;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable;
            2'd2:    readdata[WIDTH-1:0] = irqmask;
            2'd3:    readdata[WIDTH-1:0] = edgecapture;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_input_debounced.sv
// Bench for pio_input_debounced: register-access table, directed corner sequences and a
// randomized run against a history-based reference model (rising-only and any-edge builds).
module tb_pio_input_debounced;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata0, readdata2;
    logic        irq0, irq2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pio_input_debounced #(
        .WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0), .INIT_LEVEL(1'b0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata0),
        .in_port(in_port), .irq(irq0)
    );

    pio_input_debounced #(
        .WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2), .INIT_LEVEL(1'b0)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata2),
        .in_port(in_port), .irq(irq2)
    );

    // Reference model: a level is accepted once the last D synchronized samples all disagree
    // with the current accepted level. Index 0 = rising-only build, 1 = any-edge build.
    logic [7:0] m_s1, m_s2, m_stable, m_sd, m_mask;
    logic [7:0] m_ec [2];
    logic [7:0] hist [$];

    function automatic logic [31:0] m_rd(int k, logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_stable};
            2'd2:    return {24'h0, m_mask};
            2'd3:    return {24'h0, m_ec[k]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_s1 = 8'h00; m_s2 = 8'h00; m_stable = 8'h00; m_sd = 8'h00; m_mask = 8'h00;
        m_ec[0] = 8'h00; m_ec[1] = 8'h00;
        hist.delete();
    endtask

    task automatic m_tick();
        logic [7:0] ns, ev, clr;
        logic       all;
        hist.push_front(m_s2);
        if (hist.size() > D) void'(hist.pop_back());
        for (int i = 0; i < 8; i++) begin
            all = (hist.size() == D);
            foreach (hist[j]) if (hist[j][i] == m_stable[i]) all = 1'b0;
            ns[i] = all ? ~m_stable[i] : m_stable[i];
        end
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
        for (int k = 0; k < 2; k++) begin
            ev = (k == 0) ? (m_stable & ~m_sd) : (m_stable ^ m_sd);
            m_ec[k] = (m_ec[k] & ~clr) | ev;
        end
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
        m_sd     = m_stable;
        m_stable = ns;
        m_s2     = m_s1;
        m_s1     = in_port;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare against the model, then advance one clock; returns at the next falling edge.
    task automatic cycle();
        #1;
        chk("model rd0", readdata0, m_rd(0, address));
        chk("model rd2", readdata2, m_rd(1, address));
        chk("model irq0", {31'h0, irq0}, {31'h0, |(m_ec[0] & m_mask)});
        chk("model irq2", {31'h0, irq2}, {31'h0, |(m_ec[1] & m_mask)});
        @(posedge clk);
        m_tick();
        @(negedge clk);
    endtask

    task automatic idle();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cycle();
        idle();
    endtask

    task automatic rd_chk(int k, logic [1:0] a, logic [31:0] exp, string name);
        address = a;
        #1;
        chk(name, (k == 0) ? readdata0 : readdata2, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        in_port = 8'h00;
        reset_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 2'd2, 32'h0000_00A5, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 2'd2, 32'h0,         32'hA5};
        vecs[2]  = '{1'b1, 1'b1, 2'd0, 32'h0000_00FF, 32'h00};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h00};
        vecs[4]  = '{1'b1, 1'b1, 2'd1, 32'h0000_FFFF, 32'h00};
        vecs[5]  = '{1'b0, 1'b0, 2'd1, 32'h0,         32'h00};
        vecs[6]  = '{1'b0, 1'b1, 2'd2, 32'h0000_003C, 32'hA5};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'hA5};
        vecs[8]  = '{1'b1, 1'b1, 2'd2, 32'h0000_01FF, 32'hA5};
        vecs[9]  = '{1'b0, 1'b0, 2'd2, 32'h0,         32'hFF};
        vecs[10] = '{1'b1, 1'b1, 2'd3, 32'h0000_00FF, 32'h00};
        vecs[11] = '{1'b0, 1'b0, 2'd3, 32'h0,         32'h00};
        vecs[12] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'hFF};
        vecs[13] = '{1'b0, 1'b0, 2'd2, 32'h0,         32'h00};

        reset_n = 1'b0;
        address = 2'd0;
        in_port = 8'h00;
        idle();
        m_reset();
        #1;
        chk("reset irq2", {31'h0, irq2}, 32'h0);
        chk("reset data", readdata2, 32'h0);

        // Register access table
        do_reset();
        foreach (vecs[i]) begin
            address = vecs[i].addr; writedata = vecs[i].wdata;
            chipselect = vecs[i].cs; write_n = !vecs[i].wr;
            #1;
            chk($sformatf("table[%0d] rd", i), readdata2, vecs[i].exp_rd);
            chk($sformatf("table[%0d] irq", i), {31'h0, irq2}, 32'h0);
            cycle();
            idle();
        end

        // Debounce latency: accepted at edge k+5, captured at edge k+6
        do_reset();
        in_port = 8'h01;
        repeat (5) cycle();
        rd_chk(2, 2'd0, 32'h00, "latency data early");
        cycle();
        rd_chk(2, 2'd0, 32'h01, "latency data");
        rd_chk(2, 2'd3, 32'h00, "latency ec early");
        cycle();
        rd_chk(2, 2'd3, 32'h01, "latency ec");

        // Glitch of D-1 cycles rejected; a pulse of exactly D cycles passes
        do_reset();
        wr(2'd2, 32'hFF);
        in_port = 8'h08;
        repeat (D - 1) cycle();
        in_port = 8'h00;
        repeat (10) cycle();
        rd_chk(2, 2'd0, 32'h00, "glitch data");
        rd_chk(2, 2'd3, 32'h00, "glitch ec");
        chk("glitch irq", {31'h0, irq2}, 32'h0);
        in_port = 8'h08;
        repeat (D) cycle();
        in_port = 8'h00;
        repeat (12) cycle();
        rd_chk(2, 2'd3, 32'h08, "pulse D ec");
        chk("pulse D irq", {31'h0, irq2}, 32'h1);

        // IRQ masking and clear
        do_reset();
        in_port = 8'h04;
        repeat (8) cycle();
        rd_chk(2, 2'd3, 32'h04, "irq ec");
        chk("irq masked", {31'h0, irq2}, 32'h0);
        wr(2'd2, 32'h04);
        chk("irq unmasked", {31'h0, irq2}, 32'h1);
        wr(2'd3, 32'h04);
        rd_chk(2, 2'd3, 32'h00, "irq cleared ec");
        chk("irq cleared", {31'h0, irq2}, 32'h0);

        // Set beats a same-cycle clear
        do_reset();
        in_port = 8'h02;
        repeat (6) cycle();
        rd_chk(2, 2'd3, 32'h00, "collide pre");
        wr(2'd3, 32'h02);
        rd_chk(2, 2'd3, 32'h02, "collide set wins");
        wr(2'd3, 32'h02);
        rd_chk(2, 2'd3, 32'h00, "collide later clear");

        // Rising-only build
        do_reset();
        in_port = 8'h01;
        repeat (10) cycle();
        rd_chk(0, 2'd3, 32'h01, "mode0 rise");
        rd_chk(0, 2'd1, 32'h00, "mode0 reserved");
        wr(2'd3, 32'h01);
        rd_chk(0, 2'd3, 32'h00, "mode0 cleared");
        in_port = 8'h00;
        repeat (10) cycle();
        rd_chk(0, 2'd3, 32'h00, "mode0 fall ignored");
        rd_chk(2, 2'd3, 32'h01, "mode2 fall captured");
        rd_chk(0, 2'd1, 32'h00, "mode0 reserved after");

        // Asynchronous reset with a live interrupt
        do_reset();
        wr(2'd2, 32'hFF);
        in_port = 8'hFF;
        repeat (10) cycle();
        rd_chk(2, 2'd3, 32'hFF, "prereset ec");
        chk("prereset irq", {31'h0, irq2}, 32'h1);
        reset_n = 1'b0;
        in_port = 8'h00;
        m_reset();
        #1;
        chk("async reset irq2", {31'h0, irq2}, 32'h0);
        chk("async reset irq0", {31'h0, irq0}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_chk(2, 2'd0, 32'h00, "post reset data");
        rd_chk(2, 2'd2, 32'h00, "post reset mask");
        rd_chk(2, 2'd3, 32'h00, "post reset ec");

        // Randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ 8'($urandom);
            r = $urandom_range(0, 7);
            address = 2'($urandom);
            writedata = $urandom;
            chipselect = (r <= 2);
            write_n = !(r < 2);
            cycle();
        end
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
